// File: rtl/sdram_tg_pkg.sv
// Shared FSM state type, LFSR constants and pattern helper for the SDRAM traffic generator.
package sdram_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_NEXT = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_RD_NEXT = 3'd6,
    ST_DONE    = 3'd7
  } tg_state_e;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] TG_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] TG_LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] tg_lfsr_pattern(input logic [15:0] addr16);
    logic [15:0] v_seed;
    v_seed = addr16 ^ TG_LFSR_SEED;
    v_seed = (v_seed == 16'h0000) ? 16'h0001 : v_seed;
    tg_lfsr_pattern = v_seed[0] ? ({1'b0, v_seed[15:1]} ^ TG_LFSR_TAPS)
                                : {1'b0, v_seed[15:1]};
  endfunction

endpackage

// File: rtl/sdram_traffic_gen_if.sv
// User-port and status bundle between the traffic generator and the SDRAM controller / board logic.
interface sdram_traffic_gen_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16,
  parameter int ERR_W  = 16
);
  logic              start;
  logic              wr_req;
  logic              wr_ack;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data_req;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic              rd_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data_vld;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] first_err_addr;

  modport master (
    input  start, wr_ack, wr_data_req, rd_ack, rd_data_vld, rd_data,
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
           busy, done, pass, err_cnt, first_err_addr
  );

  modport slave (
    output start, wr_ack, wr_data_req, rd_ack, rd_data_vld, rd_data,
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
           busy, done, pass, err_cnt, first_err_addr
  );
endinterface

// File: rtl/sdram_tg_pattern.sv
// Address -> expected data word, shared by the write and read-check paths.
// Build option TG_LFSR_PATTERN_EN selects the LFSR pattern; otherwise the word is the address.
module sdram_tg_pattern
  import sdram_tg_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DATA_W = 16
) (
  input  logic [IN_W-1:0]   i_addr,
  output logic [DATA_W-1:0] o_pattern
);

`ifdef TG_LFSR_PATTERN_EN
  logic [15:0] w_lfsr;

  assign w_lfsr = tg_lfsr_pattern(16'(i_addr));

  // Replicate the 16-bit LFSR word across the full data width.
  always_comb begin
    o_pattern = '0;
    for (int i = 0; i < DATA_W; i++) begin
      o_pattern[i] = w_lfsr[i % 16];
    end
  end
`else
  assign o_pattern = DATA_W'(i_addr);
`endif

endmodule

// File: rtl/sdram_traffic_gen.sv
// Write-then-verify SDRAM traffic generator: writes NUM_BURSTS bursts, reads them back and checks them.
// Build option TG_LFSR_PATTERN_EN switches the data pattern from incrementing address to LFSR.
module sdram_traffic_gen
  import sdram_tg_pkg::*;
#(
  parameter int          ADDR_W     = 23,
  parameter int          DATA_W     = 16,
  parameter int          BURST_LEN  = 8,
  parameter int          NUM_BURSTS = 16,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          ERR_W      = 16
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  sdram_traffic_gen_if.master bus
);

  localparam int WC_W = (BURST_LEN  > 1) ? $clog2(BURST_LEN)  : 1;
  localparam int BC_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [WC_W-1:0]   WC_LAST = WC_W'(BURST_LEN - 1);
  localparam logic [BC_W-1:0]   BC_LAST = BC_W'(NUM_BURSTS - 1);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(BURST_LEN);
`ifdef TG_LFSR_PATTERN_EN
  localparam int PAT_IN_W = (ADDR_W < 16) ? ADDR_W : 16;
`else
  localparam int PAT_IN_W = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;
`endif

  tg_state_e         r_state;
  tg_state_e         w_next;
  logic [WC_W-1:0]   r_word_cnt;
  logic [BC_W-1:0]   r_burst_cnt;
  logic [ADDR_W-1:0] r_burst_addr;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [DATA_W-1:0] w_pattern;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_req;
  logic              r_rd_req;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [ADDR_W-1:0] r_first_err;
  logic              w_word_last;
  logic              w_burst_last;

  assign w_cur_addr   = r_burst_addr + ADDR_W'(r_word_cnt);
  assign w_word_last  = (r_word_cnt == WC_LAST);
  assign w_burst_last = (r_burst_cnt == BC_LAST);

  sdram_tg_pattern #(
    .IN_W   (PAT_IN_W),
    .DATA_W (DATA_W)
  ) u_pattern (
    .i_addr    (w_cur_addr[PAT_IN_W-1:0]),
    .o_pattern (w_pattern)
  );

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state decode; acks and data strobes count only in their own state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    w_next = bus.start ? ST_WR_REQ : ST_IDLE;
      ST_WR_REQ:  w_next = bus.wr_ack ? ST_WR_DATA : ST_WR_REQ;
      ST_WR_DATA: w_next = (bus.wr_data_req && w_word_last) ? ST_WR_NEXT : ST_WR_DATA;
      ST_WR_NEXT: w_next = w_burst_last ? ST_RD_REQ : ST_WR_REQ;
      ST_RD_REQ:  w_next = bus.rd_ack ? ST_RD_DATA : ST_RD_REQ;
      ST_RD_DATA: w_next = (bus.rd_data_vld && w_word_last) ? ST_RD_NEXT : ST_RD_DATA;
      ST_RD_NEXT: w_next = w_burst_last ? ST_DONE : ST_RD_REQ;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Registered status/request outputs derived from the upcoming state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_req <= 1'b0;
      r_rd_req <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_wr_req <= (w_next == ST_WR_REQ);
      r_rd_req <= (w_next == ST_RD_REQ);
      r_busy   <= (w_next != ST_IDLE) && (w_next != ST_DONE);
      r_done   <= (w_next == ST_DONE);
    end
  end

  // Address/counter datapath, write data register and read-back checker.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_word_cnt   <= '0;
      r_burst_cnt  <= '0;
      r_burst_addr <= '0;
      r_wr_data    <= '0;
      r_pass       <= 1'b0;
      r_err_cnt    <= '0;
      r_first_err  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_word_cnt   <= '0;
            r_burst_cnt  <= '0;
            r_burst_addr <= BASE;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_first_err  <= '0;
          end
        end
        ST_WR_DATA: begin
          if (bus.wr_data_req) begin
            r_wr_data  <= w_pattern;
            r_word_cnt <= w_word_last ? '0 : r_word_cnt + WC_W'(1);
          end
        end
        ST_WR_NEXT: begin
          if (w_burst_last) begin
            r_burst_cnt  <= '0;
            r_burst_addr <= BASE;
          end else begin
            r_burst_cnt  <= r_burst_cnt + BC_W'(1);
            r_burst_addr <= r_burst_addr + STEP;
          end
        end
        ST_RD_DATA: begin
          if (bus.rd_data_vld) begin
            r_word_cnt <= w_word_last ? '0 : r_word_cnt + WC_W'(1);
            if (bus.rd_data != w_pattern) begin
              // A zero count means this is the first mismatch of the pass.
              if (r_err_cnt == '0) begin
                r_first_err <= w_cur_addr;
              end
              if (r_err_cnt != {ERR_W{1'b1}}) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
              end
            end
          end
        end
        ST_RD_NEXT: begin
          if (w_burst_last) begin
            r_pass <= (r_err_cnt == '0);
          end else begin
            r_burst_cnt  <= r_burst_cnt + BC_W'(1);
            r_burst_addr <= r_burst_addr + STEP;
          end
        end
        default: begin
          r_word_cnt <= r_word_cnt;
        end
      endcase
    end
  end

  assign bus.wr_req         = r_wr_req;
  assign bus.wr_addr        = r_burst_addr;
  assign bus.wr_data        = r_wr_data;
  assign bus.rd_req         = r_rd_req;
  assign bus.rd_addr        = r_burst_addr;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.err_cnt        = r_err_cnt;
  assign bus.first_err_addr = r_first_err;

endmodule
